// File: rtl/osc_meas_ctrl_pkg.sv
// osc_ctrl_pkg: shared types and constants for the ring-oscillator
// measurement controller and its synchronizer.
//   - osc_state_e     : controller FSM states
//   - *_DEF           : default parameter widths
//   - OSC_SYNC_STAGES : metastability flops ahead of the edge-detect register
package osc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } osc_state_e;

  localparam int CNT_W_DEF       = 16;
  localparam int WIN_W_DEF       = 16;
  localparam int SETTLE_W_DEF    = 8;
  localparam int OSC_SYNC_STAGES = 2;

endpackage

// File: rtl/osc_sync_edge.sv
// osc_sync_edge: brings an asynchronous level into the clk domain through a
// STAGES-deep synchronizer and flags its rising edges with one extra register.
// Shared by the oscillator path and other asynchronous analog-status inputs.
// Ports:
//   i_clk   - system clock
//   i_rst   - synchronous active-high reset
//   i_async - asynchronous input level
//   o_rise  - one-cycle pulse when the synchronized level goes 0 -> 1
// STAGES must be at least 2.
module osc_sync_edge
  import osc_ctrl_pkg::*;
#(
  parameter int STAGES = OSC_SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Synchronizer shift chain plus the delayed copy used for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/osc_meas_ctrl.sv
// osc_meas_ctrl: enables the ring oscillator, waits a settle time, counts
// synchronized rising edges of osc_in over a window of clk cycles and hands
// the count to the host through result_valid/result_ready.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   start, abort              - begin measurement (IDLE only) / force IDLE
//   window_len, settle_len    - latched on accepted start
//   cont_mode                 - continuous re-measure request
//   osc_in                    - asynchronous oscillator output
//   osc_en, busy              - oscillator enable, not-IDLE indicator
//   result, overflow          - last window's count and saturation flag
//   result_valid/result_ready - host handshake
// Build option: define OSC_CONT_EN to enable continuous measurement; without
// it cont_mode is ignored and every measurement is single-shot.
module osc_meas_ctrl
  import osc_ctrl_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int WIN_W    = WIN_W_DEF,
  parameter int SETTLE_W = SETTLE_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [WIN_W-1:0]    window_len,
  input  logic [SETTLE_W-1:0] settle_len,
  input  logic                cont_mode,
  input  logic                osc_in,
  output logic                osc_en,
  output logic                busy,
  output logic [CNT_W-1:0]    result,
  output logic                overflow,
  output logic                result_valid,
  input  logic                result_ready
);

  // One down-counter serves both the settle and the measure phases.
  localparam int TMR_W = (WIN_W > SETTLE_W) ? WIN_W : SETTLE_W;

  osc_state_e       r_state;
  logic [TMR_W-1:0] r_tmr;
  logic [WIN_W-1:0] r_win;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_win;
  logic             r_osc_en;
  logic             r_busy;
  logic             r_valid;
  logic [CNT_W-1:0] r_result;
  logic             r_overflow;

  logic             w_rise;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_ovf_next;
  logic [TMR_W-1:0] w_settle_m1;
  logic [TMR_W-1:0] w_win_m1;

`ifdef OSC_CONT_EN
  logic r_cont;
`else
  logic w_unused_cont;
  assign w_unused_cont = cont_mode;
`endif

  osc_sync_edge #(
    .STAGES (OSC_SYNC_STAGES)
  ) u_sync (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_async (osc_in),
    .o_rise  (w_rise)
  );

  // Saturating edge count and timer reload values (zero lengths act as one).
  always_comb begin
    w_cnt_next = r_cnt;
    w_ovf_next = r_ovf_win;
    if (w_rise) begin
      if (r_cnt == {CNT_W{1'b1}}) begin
        w_ovf_next = 1'b1;
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1'b1);
      end
    end else begin
      w_cnt_next = r_cnt;
    end
    if (settle_len == {SETTLE_W{1'b0}}) begin
      w_settle_m1 = {TMR_W{1'b0}};
    end else begin
      w_settle_m1 = TMR_W'(settle_len) - TMR_W'(1'b1);
    end
    if (r_win == {WIN_W{1'b0}}) begin
      w_win_m1 = {TMR_W{1'b0}};
    end else begin
      w_win_m1 = TMR_W'(r_win) - TMR_W'(1'b1);
    end
  end

  // Measurement FSM with registered outputs; abort overrides everything but rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tmr      <= {TMR_W{1'b0}};
      r_win      <= {WIN_W{1'b0}};
      r_cnt      <= {CNT_W{1'b0}};
      r_ovf_win  <= 1'b0;
      r_osc_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_result   <= {CNT_W{1'b0}};
      r_overflow <= 1'b0;
`ifdef OSC_CONT_EN
      r_cont     <= 1'b0;
`endif
    end else if (abort) begin
      r_state  <= IDLE;
      r_osc_en <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= SETTLE;
            r_win    <= window_len;
            r_tmr    <= w_settle_m1;
            r_osc_en <= 1'b1;
            r_busy   <= 1'b1;
`ifdef OSC_CONT_EN
            r_cont   <= cont_mode;
`endif
          end
        end
        SETTLE: begin
          if (r_tmr == {TMR_W{1'b0}}) begin
            r_state   <= MEASURE;
            r_tmr     <= w_win_m1;
            r_cnt     <= {CNT_W{1'b0}};
            r_ovf_win <= 1'b0;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1'b1);
          end
        end
        MEASURE: begin
          r_cnt     <= w_cnt_next;
          r_ovf_win <= w_ovf_next;
          if (r_tmr == {TMR_W{1'b0}}) begin
            // Capture includes an edge detected in this final cycle.
            r_state    <= DONE;
            r_result   <= w_cnt_next;
            r_overflow <= w_ovf_next;
            r_valid    <= 1'b1;
`ifdef OSC_CONT_EN
            r_osc_en   <= r_cont;
`else
            r_osc_en   <= 1'b0;
`endif
          end else begin
            r_tmr <= r_tmr - TMR_W'(1'b1);
          end
        end
        DONE: begin
          if (result_ready) begin
            r_valid <= 1'b0;
`ifdef OSC_CONT_EN
            if (r_cont && cont_mode) begin
              // Oscillator is already running: skip the settle phase.
              r_state   <= MEASURE;
              r_tmr     <= w_win_m1;
              r_cnt     <= {CNT_W{1'b0}};
              r_ovf_win <= 1'b0;
            end else begin
              r_state  <= IDLE;
              r_osc_en <= 1'b0;
              r_busy   <= 1'b0;
            end
`else
            r_state  <= IDLE;
            r_osc_en <= 1'b0;
            r_busy   <= 1'b0;
`endif
          end
        end
        default: begin
          r_state  <= IDLE;
          r_osc_en <= 1'b0;
          r_busy   <= 1'b0;
          r_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign osc_en       = r_osc_en;
  assign busy         = r_busy;
  assign result       = r_result;
  assign overflow     = r_overflow;
  assign result_valid = r_valid;

endmodule

// File: tb/tb_osc_meas_ctrl.sv
// Directed bench for osc_meas_ctrl: a table of measurements on a 16-bit and a
// 4-bit-count instance, plus hand-written abort / continuous-mode sequences.
// Latencies count clk cycles from the cycle in which start is high
// (start cycle = 0): result_valid appears in cycle 1 + max(S,1) + max(W,1).
module tb_osc_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, start_b, abort, cont_mode, osc_in, result_ready;
  logic [15:0] window_len;
  logic [7:0]  settle_len;
  logic        osc_en, busy, overflow, result_valid;
  logic [15:0] result;
  logic        osc_en_b, busy_b, overflow_b, result_valid_b;
  logic [3:0]  result_b;

  int   n_checks = 0;
  int   n_errors = 0;
  int   osc_mode = 0;
  logic [1:0] ph;
  bit   sel_b = 1'b0;

  wire        m_valid  = sel_b ? result_valid_b : result_valid;
  wire        m_osc_en = sel_b ? osc_en_b : osc_en;
  wire        m_busy   = sel_b ? busy_b : busy;
  wire        m_ovf    = sel_b ? overflow_b : overflow;
  wire [15:0] m_result = sel_b ? {12'h000, result_b} : result;

  always #5 clk = ~clk;

  osc_meas_ctrl dut (
    .clk (clk), .rst (rst), .start (start), .abort (abort),
    .window_len (window_len), .settle_len (settle_len), .cont_mode (cont_mode),
    .osc_in (osc_in), .osc_en (osc_en), .busy (busy), .result (result),
    .overflow (overflow), .result_valid (result_valid), .result_ready (result_ready)
  );

  osc_meas_ctrl #(.CNT_W(4)) dut_b (
    .clk (clk), .rst (rst), .start (start_b), .abort (abort),
    .window_len (window_len), .settle_len (settle_len), .cont_mode (cont_mode),
    .osc_in (osc_in), .osc_en (osc_en_b), .busy (busy_b), .result (result_b),
    .overflow (overflow_b), .result_valid (result_valid_b), .result_ready (result_ready)
  );

  // Oscillator model: 0 = held low, 1 = period 2 clk, 2 = period 4 clk.
  initial begin
    osc_in = 1'b0;
    ph     = 2'd0;
    forever begin
      @(negedge clk);
      case (osc_mode)
        0: osc_in = 1'b0;
        1: osc_in = ~osc_in;
        default: begin
          ph     = ph + 2'd1;
          osc_in = ph[1];
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [7:0]  settle;
    logic [15:0] win;
    int          mode;
    bit          use_b;
    bit          poke;
    int          exp_lat;
    int          exp_res;
    int          exp_ovf;
  } vec_t;

  vec_t vecs[7];

  // One single-shot measurement: start, wait for valid, check, handshake.
  task automatic run_meas(input vec_t v);
    int lat;
    bit got;
    logic [15:0] res_seen;
    sel_b     = v.use_b;
    osc_mode  = v.mode;
    cont_mode = 1'b0;
    repeat (4) @(negedge clk);
    settle_len = v.settle;
    window_len = v.win;
    if (v.use_b) start_b = 1'b1; else start = 1'b1;
    lat = 0;
    got = 1'b0;
    while (lat < 400 && !got) begin
      @(negedge clk);
      start   = 1'b0;
      start_b = 1'b0;
      lat++;
      if (lat == 1) begin
        chk({v.name, "_osc_en_rise"}, {31'd0, m_osc_en}, 32'd1);
        chk({v.name, "_busy_rise"}, {31'd0, m_busy}, 32'd1);
      end
      if (v.poke && lat == 8) begin
        // start while busy must be ignored, including the new lengths
        start      = 1'b1;
        window_len = 16'd2;
        settle_len = 8'd0;
      end
      if (m_valid) got = 1'b1;
    end
    chk({v.name, "_latency"}, lat, v.exp_lat);
    chk({v.name, "_result"}, {16'd0, m_result}, v.exp_res);
    chk({v.name, "_overflow"}, {31'd0, m_ovf}, v.exp_ovf);
    chk({v.name, "_osc_en_done"}, {31'd0, m_osc_en}, 32'd0);
    res_seen = m_result;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk({v.name, "_valid_clr"}, {31'd0, m_valid}, 32'd0);
    chk({v.name, "_idle"}, {31'd0, m_busy}, 32'd0);
    chk({v.name, "_res_hold"}, {16'd0, m_result}, {16'd0, res_seen});
    sel_b = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  seen;
    rst = 1'b1; start = 1'b0; start_b = 1'b0; abort = 1'b0; cont_mode = 1'b0;
    result_ready = 1'b0; window_len = 16'd0; settle_len = 8'd0;

    vecs[0] = '{"tog16",   8'd4,  16'd16,  1, 1'b0, 1'b0, 21,  8,  0};
    vecs[1] = '{"poke",    8'd4,  16'd16,  1, 1'b0, 1'b1, 21,  8,  0};
    vecs[2] = '{"zero",    8'd0,  16'd0,   0, 1'b0, 1'b0, 3,   0,  0};
    vecs[3] = '{"hold100", 8'd4,  16'd100, 0, 1'b0, 1'b0, 105, 0,  0};
    vecs[4] = '{"sat4",    8'd3,  16'd64,  1, 1'b1, 1'b0, 68,  15, 1};
    vecs[5] = '{"p4w20",   8'd2,  16'd20,  2, 1'b0, 1'b0, 23,  5,  0};
    vecs[6] = '{"p2w8",    8'd1,  16'd8,   1, 1'b0, 1'b0, 10,  4,  0};

    // Reset held three cycles, then twenty quiet idle cycles.
    repeat (3) @(negedge clk);
    chk("rst_state", {osc_en, busy, result_valid, overflow, result}, 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({osc_en, busy, result_valid, overflow, result} != 20'd0) seen = 1'b1;
      if ({osc_en_b, busy_b, result_valid_b, overflow_b, result_b} != 8'd0) seen = 1'b1;
    end
    chk("idle_quiet", {31'd0, seen}, 32'd0);

    for (int i = 0; i < 7; i++) run_meas(vecs[i]);

    // Abort in the middle of MEASURE: result from "p2w8" (4) is kept.
    osc_mode = 1;
    settle_len = 8'd2; window_len = 16'd50;
    start = 1'b1;
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort_pre_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_osc_en", {31'd0, osc_en}, 32'd0);
    chk("abort_result", {16'd0, result}, 32'd4);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (result_valid || busy) seen = 1'b1;
    end
    chk("abort_no_valid", {31'd0, seen}, 32'd0);

    // abort and start together in IDLE: start is dropped.
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_start_busy", {31'd0, busy}, 32'd0);
    chk("abort_start_osc", {31'd0, osc_en}, 32'd0);
    repeat (5) @(negedge clk);
    chk("abort_start_stay", {30'd0, busy, result_valid}, 32'd0);

    // Abort while DONE is waiting for the host: valid drops, result stays.
    osc_mode = 0;
    repeat (4) @(negedge clk);
    settle_len = 8'd0; window_len = 16'd0;
    start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("done_valid", {31'd0, result_valid}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("done_abort_valid", {30'd0, result_valid, busy}, 32'd0);
    chk("done_abort_result", {16'd0, result}, 32'd0);

    // result_ready with nothing pending has no effect.
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("ready_idle", {30'd0, busy, result_valid}, 32'd0);

`ifdef OSC_CONT_EN
    // Continuous mode: back-to-back windows, oscillator never disabled.
    osc_mode = 2;
    repeat (4) @(negedge clk);
    settle_len = 8'd2; window_len = 16'd32; cont_mode = 1'b1;
    start = 1'b1;
    lat = 0; seen = 1'b0;
    while (lat < 400 && !result_valid) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (!osc_en) seen = 1'b1;
    end
    chk("cont_lat1", lat, 35);
    chk("cont_res1", {16'd0, result}, 32'd8);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!osc_en || !result_valid || result != 16'd8) seen = 1'b1;
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("cont_hs_valid", {31'd0, result_valid}, 32'd0);
    chk("cont_hs_busy", {31'd0, busy}, 32'd1);
    lat = 0;
    while (lat < 400 && !result_valid) begin
      @(negedge clk);
      lat++;
      if (!osc_en) seen = 1'b1;
    end
    chk("cont_lat2", lat, 32);
    chk("cont_res2", {16'd0, result}, 32'd8);
    chk("cont_osc_stable", {31'd0, seen}, 32'd0);
    cont_mode = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("cont_end", {29'd0, busy, osc_en, result_valid}, 32'd0);
`else
    // Without the option cont_mode is ignored: single-shot behaviour.
    osc_mode = 1;
    repeat (4) @(negedge clk);
    settle_len = 8'd1; window_len = 16'd8; cont_mode = 1'b1;
    start = 1'b1;
    lat = 0;
    while (lat < 400 && !result_valid) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    chk("nocont_lat", lat, 10);
    chk("nocont_osc_en", {31'd0, osc_en}, 32'd0);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    cont_mode = 1'b0;
    chk("nocont_idle", {29'd0, busy, osc_en, result_valid}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
